polyshift_seq: RTL and testbench
================================

// Module: polyshift_seq
// PURPOSE
//  Multi-word right-shift sequencer built around one shared polyshift_r.
//  Accepts a WORD_COUNT-word operand, shifts it right by 0..WORD_WIDTH-1 bits
//  one word per cycle (LSW first), and chains carries between words via the RCR mode.
//  Sits between the ALU issue stage and the writeback path for wide (multi-word) shifts.
// PARAMETERS
//  WORD_WIDTH  8  bits per word; width of the internal polyshift_r
//  WORD_COUNT  4  words per operand (>=2); operand width = WORD_COUNT*WORD_WIDTH
// PORTS
//  clk_i           in   1                         clock
//  rst_i           in   1                         synchronous reset, active-high
//  valid_i         in   1                         request valid
//  ready_o         out  1                         sequencer can accept (IDLE and rst_i low)
//  data_i          in   WORD_COUNT*WORD_WIDTH     operand, word 0 = LSW
//  c_i             in   WORD_WIDTH-1              carry-in bits for RCR type
//  shift_size_i    in   $clog2(WORD_WIDTH)        shift amount
//  shift_type_i    in   SHIFT_TYPE                LOGIC / ARITH / RCR / ROR
//  valid_o         out  1                         result valid
//  ready_i         in   1                         consumer accepts result
//  data_o          out  WORD_COUNT*WORD_WIDTH     shifted operand
//  busy_o          out  1                         high in BUSY
// BEHAVIOUR
//  Reset (rst_i=1 at posedge): state=IDLE, idx=0, buffer=0, saved LSW=0; valid_o=0,
//   data_o=0, busy_o=0. ready_o is 0 while rst_i is high and 1 in the first cycle after.
//   Reset in any state (incl. mid-BUSY) aborts the operation; the result is discarded.
//  States: IDLE -> BUSY -> DONE -> IDLE.
//   IDLE: ready_o=1. On valid_i&ready_o: latch data_i into buffer, latch
//    word 0 into saved LSW, latch c_i/shift_size_i/shift_type_i, idx=0, go BUSY.
//   BUSY: each cycle drive polyshift_r with D=buffer[idx], size=latched size.
//    idx<WORD_COUNT-1: type RCR, C=buffer[idx+1][WORD_WIDTH-2:0] (still unmodified).
//    idx=WORD_COUNT-1: LOGIC->LOGIC; ARITH->ARITH; RCR->RCR with C=latched c_i;
//     ROR->RCR with C=saved LSW[WORD_WIDTH-2:0] (original word 0, not shifted).
//    Result written to buffer[idx] at the edge; idx++. After writing idx=WORD_COUNT-1
//    go DONE. Exactly WORD_COUNT cycles in BUSY; valid_i ignored.
//   DONE: valid_o=1, data_o=buffer, held stable until valid_o&ready_i; then IDLE.
//    No accept in the same cycle as the result handshake (ready_o=0 in DONE).
//  Latency: accept edge T -> valid_o high from edge T+WORD_COUNT; throughput one op
//   per WORD_COUNT+2 cycles with ready_i held high.
//  data_o: registered buffer, visible (but not valid) in every state; equals last
//   result in IDLE until next accept.
//  Result equals full-width reference: LOGIC = x>>s; ARITH = $signed(x)>>>s;
//   RCR = ({c_i,x}>>s)[low]; ROR = rotate-right of x by s. s=0 returns x for all types.
//  shift_type_i / shift_size_i / c_i changes after accept have no effect.
// TESTING (WORD_WIDTH=8, WORD_COUNT=4)
//  LOGIC, x=0x80000001, s=1 -> 0x40000000; valid_o exactly 4 cycles after accept.
//  ARITH, x=0x80000000, s=4 -> 0xF8000000; ARITH x=0x7FFFFFFF, s=7 -> 0x00FFFFFF.
//  ROR, x=0x12345678, s=4 -> 0x81234567; ROR s=0 -> 0x12345678.
//  RCR, x=0x000000FF, c_i=7'h7F, s=7 -> 0xFE000001.
//  Backpressure: ready_i=0 for 3 cycles in DONE -> valid_o/data_o held, ready_o=0,
//   valid_i pulses ignored; ready_i=1 -> IDLE next cycle, ready_o=1.
//  Reset asserted at idx=2 of BUSY -> next cycle IDLE, valid_o=0, data_o=0,
//   busy_o=0; following request completes correctly with no residue.

Source files
------------

// File: rtl/polyshift_seq_if.sv
// Request/result bundle for the multi-word shift sequencer.
// The slave side is the sequencer; the master side is the issue stage and the writeback consumer.
interface polyshift_seq_if #(
    parameter int WORD_WIDTH = 8,
    parameter int WORD_COUNT = 4
);
    logic                               valid_i;
    logic                               ready_o;
    logic [WORD_COUNT*WORD_WIDTH-1:0]   data_i;
    logic [WORD_WIDTH-2:0]              c_i;
    logic [$clog2(WORD_WIDTH)-1:0]      shift_size_i;
    logic [1:0]                         shift_type_i;
    logic                               valid_o;
    logic                               ready_i;
    logic [WORD_COUNT*WORD_WIDTH-1:0]   data_o;
    logic                               busy_o;

    modport slave (
        input  valid_i, data_i, c_i, shift_size_i, shift_type_i, ready_i,
        output ready_o, valid_o, data_o, busy_o
    );

    modport master (
        output valid_i, data_i, c_i, shift_size_i, shift_type_i, ready_i,
        input  ready_o, valid_o, data_o, busy_o
    );
endinterface

// File: rtl/polyshift_seq.sv
// Wide right-shift sequencer: shifts a WORD_COUNT-word operand one word per cycle (LSW first)
// through a single word-wide shifter, chaining carry bits from the next-higher word.
module polyshift_seq #(
    parameter int WORD_WIDTH = 8,
    parameter int WORD_COUNT = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    polyshift_seq_if.slave  bus
);
    localparam int SW = $clog2(WORD_WIDTH);
    localparam int IW = $clog2(WORD_COUNT);
    localparam logic [IW-1:0] LAST_IDX = IW'(WORD_COUNT - 1);

    localparam logic [1:0] T_LOGIC = 2'd0;
    localparam logic [1:0] T_ARITH = 2'd1;
    localparam logic [1:0] T_RCR   = 2'd2;
    localparam logic [1:0] T_ROR   = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                                 state_reg, state_next;
    logic [IW-1:0]                          idx_reg, idx_next;
    logic [WORD_COUNT-1:0][WORD_WIDTH-1:0]  buf_reg, buf_next;
    logic [WORD_WIDTH-2:0]                  lsw_reg, lsw_next;
    logic [WORD_WIDTH-2:0]                  c_reg, c_next;
    logic [SW-1:0]                          size_reg, size_next;
    logic [1:0]                             type_reg, type_next;

    logic [WORD_WIDTH-1:0]                  cur_word;
    logic [WORD_WIDTH-1:0]                  upper_word;
    logic [WORD_WIDTH-2:0]                  carry_word;
    logic [2*WORD_WIDTH-2:0]                shifted;
    logic [WORD_WIDTH-1:0]                  shift_result;

    // Word shifter: every mode is a funnel shift of {fill, word}; only the fill differs.
    // Lower words always take the still-unshifted bits of the word above them.
    always_comb begin
        cur_word   = buf_reg[idx_reg];
        upper_word = buf_reg[idx_reg + 1'b1];
        carry_word = '0;
        if (idx_reg != LAST_IDX) begin
            carry_word = upper_word[WORD_WIDTH-2:0];
        end else begin
            case (type_reg)
                T_LOGIC: carry_word = '0;
                T_ARITH: carry_word = {(WORD_WIDTH-1){cur_word[WORD_WIDTH-1]}};
                T_RCR:   carry_word = c_reg;
                T_ROR:   carry_word = lsw_reg;
                default: carry_word = '0;
            endcase
        end
        shifted      = {carry_word, cur_word} >> size_reg;
        shift_result = shifted[WORD_WIDTH-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= S_IDLE;
            idx_reg   <= '0;
            buf_reg   <= '0;
            lsw_reg   <= '0;
            c_reg     <= '0;
            size_reg  <= '0;
            type_reg  <= T_LOGIC;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            buf_reg   <= buf_next;
            lsw_reg   <= lsw_next;
            c_reg     <= c_next;
            size_reg  <= size_next;
            type_reg  <= type_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        buf_next   = buf_reg;
        lsw_next   = lsw_reg;
        c_next     = c_reg;
        size_next  = size_reg;
        type_next  = type_reg;
        case (state_reg)
            S_IDLE: begin
                if (bus.valid_i) begin
                    buf_next   = bus.data_i;
                    lsw_next   = bus.data_i[WORD_WIDTH-2:0];
                    c_next     = bus.c_i;
                    size_next  = bus.shift_size_i;
                    type_next  = bus.shift_type_i;
                    idx_next   = '0;
                    state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                buf_next[idx_reg] = shift_result;
                idx_next          = idx_reg + 1'b1;
                if (idx_reg == LAST_IDX) begin
                    idx_next   = '0;
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.ready_i) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.ready_o = (state_reg == S_IDLE) && !rst_i;
        bus.valid_o = (state_reg == S_DONE);
        bus.busy_o  = (state_reg == S_BUSY);
    end

    for (genvar gi = 0; gi < WORD_COUNT; gi++) begin : g_out
        assign bus.data_o[gi*WORD_WIDTH +: WORD_WIDTH] = buf_reg[gi];
    end
endmodule

// File: tb/tb_polyshift_seq.sv
// Randomized and directed check of polyshift_seq against a full-width arithmetic reference.
module tb_polyshift_seq;
    localparam int W = 8;
    localparam int N = 4;
    localparam int XW = W * N;

    localparam logic [1:0] T_LOGIC = 2'd0;
    localparam logic [1:0] T_ARITH = 2'd1;
    localparam logic [1:0] T_RCR   = 2'd2;
    localparam logic [1:0] T_ROR   = 2'd3;

    logic clk = 1'b0;
    logic rst_i;
    int   n_cmp = 0;
    int   n_bad = 0;

    polyshift_seq_if #(.WORD_WIDTH(W), .WORD_COUNT(N)) psif ();

    polyshift_seq #(.WORD_WIDTH(W), .WORD_COUNT(N)) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (psif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [XW-1:0] ref_shift(input logic [XW-1:0] x, input logic [W-2:0] c,
                                                input int s, input logic [1:0] t);
        logic [XW+W-2:0] cat;
        logic [2*XW-1:0] dbl;
        logic [XW-1:0]   r;
        case (t)
            T_LOGIC: r = x >> s;
            T_ARITH: r = $signed(x) >>> s;
            T_RCR: begin
                cat = {c, x} >> s;
                r   = cat[XW-1:0];
            end
            default: begin
                dbl = {x, x} >> s;
                r   = dbl[XW-1:0];
            end
        endcase
        return r;
    endfunction

    // Issues one request, checks latency and result, optionally stalls the result for hold cycles.
    task automatic run_op(input logic [XW-1:0] x, input logic [W-2:0] c, input int s,
                          input logic [1:0] t, input logic [XW-1:0] exp, input int hold);
        int cyc;
        check("ready_idle", psif.ready_o, 1);
        psif.valid_i      = 1'b1;
        psif.data_i       = x;
        psif.c_i          = c;
        psif.shift_size_i = s[2:0];
        psif.shift_type_i = t;
        @(negedge clk);
        psif.valid_i      = 1'b0;
        psif.data_i       = $urandom;
        psif.c_i          = 7'($urandom);
        psif.shift_size_i = 3'($urandom);
        psif.shift_type_i = 2'($urandom);
        check("busy", psif.busy_o, 1);
        cyc = 0;
        while (!psif.valid_o && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", cyc, N);
        check("result", psif.data_o, exp);
        check("ready_done", psif.ready_o, 0);
        $display("op type=%0d s=%0d x=%h c=%h -> %h (exp %h)", t, s, x, c, psif.data_o, exp);
        for (int i = 0; i < hold; i++) begin
            psif.valid_i = i[0];
            @(negedge clk);
            check("hold_valid", psif.valid_o, 1);
            check("hold_data", psif.data_o, exp);
            check("hold_ready", psif.ready_o, 0);
        end
        psif.valid_i = 1'b0;
        psif.ready_i = 1'b1;
        @(negedge clk);
        psif.ready_i = 1'b0;
        check("post_valid", psif.valid_o, 0);
        check("post_ready", psif.ready_o, 1);
        check("post_data", psif.data_o, exp);
    endtask

    initial begin
        logic [XW-1:0] x;
        logic [W-2:0]  c;
        int            s;
        logic [1:0]    t;

        rst_i             = 1'b1;
        psif.valid_i      = 1'b0;
        psif.ready_i      = 1'b0;
        psif.data_i       = '0;
        psif.c_i          = '0;
        psif.shift_size_i = '0;
        psif.shift_type_i = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", psif.ready_o, 0);
        check("rst_valid", psif.valid_o, 0);
        check("rst_data", psif.data_o, 0);
        check("rst_busy", psif.busy_o, 0);
        rst_i = 1'b0;
        #1;
        check("rst_rel_ready", psif.ready_o, 1);
        @(negedge clk);

        run_op(32'h80000001, 7'h00, 1, T_LOGIC, 32'h40000000, 0);
        run_op(32'h80000000, 7'h00, 4, T_ARITH, 32'hF8000000, 0);
        run_op(32'h7FFFFFFF, 7'h00, 7, T_ARITH, 32'h00FFFFFF, 0);
        run_op(32'h12345678, 7'h00, 4, T_ROR,   32'h81234567, 0);
        run_op(32'h12345678, 7'h55, 0, T_ROR,   32'h12345678, 0);
        run_op(32'h000000FF, 7'h7F, 7, T_RCR,   32'hFE000001, 3);

        // Abort mid-operation with a reset at idx=2.
        psif.valid_i      = 1'b1;
        psif.data_i       = 32'hDEADBEEF;
        psif.c_i          = 7'h3C;
        psif.shift_size_i = 3'd3;
        psif.shift_type_i = T_RCR;
        @(negedge clk);
        psif.valid_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        #1;
        check("abort_ready_in_rst", psif.ready_o, 0);
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        check("abort_valid", psif.valid_o, 0);
        check("abort_data", psif.data_o, 0);
        check("abort_busy", psif.busy_o, 0);
        check("abort_ready", psif.ready_o, 1);
        @(negedge clk);
        run_op(32'hA5A5F00F, 7'h01, 5, T_ARITH, ref_shift(32'hA5A5F00F, 7'h01, 5, T_ARITH), 0);

        for (int k = 0; k < 40; k++) begin
            x = $urandom;
            c = 7'($urandom_range(0, 127));
            s = $urandom_range(0, W - 1);
            t = 2'($urandom_range(0, 3));
            run_op(x, c, s, t, ref_shift(x, c, s, t), $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
